// File: rtl/alu_ctrl_pkg.sv
// Shared constants and FSM state type for the EX-stage ALU control unit.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  localparam logic [1:0] OP_LDST  = 2'b00;
  localparam logic [1:0] OP_BEQ   = 2'b01;
  localparam logic [1:0] OP_ADDI  = 2'b10;
  localparam logic [1:0] OP_RTYPE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_RUN  = 2'd1,
    S_MUL_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALUOp/funct decode into the 4-bit ALU control code.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       illegal
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      OP_LDST:  code = ALU_ADD;
      OP_BEQ:   code = ALU_SUB;
      OP_ADDI:  code = ALU_ADD;
      default: begin
        case (funct)
          F_ADD:   code = ALU_ADD;
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_NOR:   code = ALU_NOR;
          F_SLT:   code = ALU_SLT;
          F_MUL:   code = ALU_MUL;
          F_SLL:   code = ALU_SLL;
          F_SRL:   code = ALU_SRL;
          default: begin
            code    = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control with a MUL sequencer (start pulse, busy stall, done).
//   state      | meaning
//   S_IDLE     | accepting instructions, decode captured when valid and not stalled
//   S_MUL_RUN  | multiplier iterating, busy_o held, counter counts down to 0
//   S_MUL_DONE | result valid on done_o, held until stall_i drops
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CTRL_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic              stall_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              mul_start_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              illegal_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             capture;

  alu_funct_decode u_decode (
    .alu_op  (ALUOp_i),
    .funct   (funct_i),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  assign capture = (state == S_IDLE) && valid_i && !stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      count       <= '0;
      ALUCtrl_o   <= CTRL_W'(ALU_ADD);
      mul_start_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      mul_start_o <= 1'b0;
      illegal_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (capture) begin
            ALUCtrl_o <= CTRL_W'(dec_code);
            illegal_o <= dec_illegal;
            if (dec_code == ALU_MUL) begin
              state       <= S_MUL_RUN;
              count       <= CNT_W'(MUL_LAT - 1);
              mul_start_o <= 1'b1;
              busy_o      <= 1'b1;
            end
          end
        end
        // The multiplier free-runs, so the countdown ignores stall_i.
        S_MUL_RUN: begin
          if (count == '0) begin
            state  <= S_MUL_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        S_MUL_DONE: begin
          if (!stall_i) begin
            state  <= S_IDLE;
            done_o <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
